// File: rtl/sop_cube_evaluator.sv
// Sequential sum-of-products evaluator: scans a loadable cube table one entry per cycle, first hit wins.
// Optional out_hit_idx port and its register are built only when SOP_HIT_IDX_EN is defined.
module sop_cube_evaluator #(
    parameter int N_VARS    = 5,
    parameter int MAX_CUBES = 8,
    localparam int IDX_W    = (MAX_CUBES > 1) ? $clog2(MAX_CUBES) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_we,
    input  logic [IDX_W-1:0]  cfg_idx,
    input  logic [N_VARS-1:0] cfg_care,
    input  logic [N_VARS-1:0] cfg_val,
    input  logic              cfg_en,
    output logic              cfg_ready,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N_VARS-1:0] in_x,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_f,
`ifdef SOP_HIT_IDX_EN
    output logic [IDX_W-1:0]  out_hit_idx,
`endif
    output logic [1:0]        o_dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MAX_CUBES - 1);

    state_t              r_state;
    logic [IDX_W-1:0]    r_idx;
    logic [N_VARS-1:0]   r_x;
    logic                r_out_valid;
    logic                r_f;
`ifdef SOP_HIT_IDX_EN
    logic [IDX_W-1:0]    r_hit_idx;
`endif

    logic [N_VARS-1:0]   r_care [MAX_CUBES];
    logic [N_VARS-1:0]   r_val  [MAX_CUBES];
    logic                r_en   [MAX_CUBES];

    logic                w_idx_ok;
    logic                w_hit;

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
    // Ready depends only on state and rst; valid is registered and held until taken.
    assign in_ready    = (r_state == S_IDLE) && !rst;
    assign cfg_ready   = (r_state == S_IDLE) && !rst;
    assign out_valid   = r_out_valid;
    assign out_f       = r_f;
`ifdef SOP_HIT_IDX_EN
    assign out_hit_idx = r_hit_idx;
`endif
    assign o_dbg_state = r_state;

    // With a power-of-two depth every index is in range; otherwise drop out-of-range writes.
    if ((1 << IDX_W) == MAX_CUBES) begin : g_idx_pow2
        assign w_idx_ok = 1'b1;
    end else begin : g_idx_range
        assign w_idx_ok = ({1'b0, cfg_idx} < (IDX_W + 1)'(MAX_CUBES));
    end

    assign w_hit = r_en[r_idx] && (((r_x ^ r_val[r_idx]) & r_care[r_idx]) == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < MAX_CUBES; k++) begin
                r_care[k] <= '0;
                r_val[k]  <= '0;
                r_en[k]   <= 1'b0;
            end
        end else if ((r_state == S_IDLE) && cfg_we && w_idx_ok) begin
            r_care[cfg_idx] <= cfg_care;
            r_val[cfg_idx]  <= cfg_val;
            r_en[cfg_idx]   <= cfg_en;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_x         <= '0;
            r_out_valid <= 1'b0;
            r_f         <= 1'b0;
`ifdef SOP_HIT_IDX_EN
            r_hit_idx   <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_x     <= in_x;
                        r_idx   <= '0;
                        r_state <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (w_hit) begin
                        r_f         <= 1'b1;
`ifdef SOP_HIT_IDX_EN
                        r_hit_idx   <= r_idx;
`endif
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else if (r_idx == LAST_IDX) begin
                        r_f         <= 1'b0;
`ifdef SOP_HIT_IDX_EN
                        r_hit_idx   <= '0;
`endif
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sop_cube_evaluator.sv
// Directed bench for sop_cube_evaluator: hand-computed vectors for hit, miss, backpressure and reset behaviour.
module tb_sop_cube_evaluator;

    localparam int N_VARS    = 5;
    localparam int MAX_CUBES = 8;
    localparam int IDX_W     = 3;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cfg_we = 1'b0;
    logic [IDX_W-1:0]  cfg_idx = '0;
    logic [N_VARS-1:0] cfg_care = '0;
    logic [N_VARS-1:0] cfg_val = '0;
    logic              cfg_en = 1'b0;
    logic              cfg_ready;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [N_VARS-1:0] in_x = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic              out_f;
`ifdef SOP_HIT_IDX_EN
    logic [IDX_W-1:0]  out_hit_idx;
`endif
    logic [1:0]        dbg_state;

    int n_cmp = 0;
    int n_err = 0;

    sop_cube_evaluator #(.N_VARS(N_VARS), .MAX_CUBES(MAX_CUBES)) dut (
        .clk(clk), .rst(rst),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_care(cfg_care), .cfg_val(cfg_val),
        .cfg_en(cfg_en), .cfg_ready(cfg_ready),
        .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x),
        .out_valid(out_valid), .out_ready(out_ready), .out_f(out_f),
`ifdef SOP_HIT_IDX_EN
        .out_hit_idx(out_hit_idx),
`endif
        .o_dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
        n_cmp++;
        assert (obs === req) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, req);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst/in_ready", in_ready, 0);
        chk("rst/cfg_ready", cfg_ready, 0);
        chk("rst/out_valid", out_valid, 0);
        chk("rst/out_f", out_f, 0);
`ifdef SOP_HIT_IDX_EN
        chk("rst/hit_idx", out_hit_idx, 0);
`endif
        rst = 1'b0;
        @(negedge clk);
        chk("rst/idle_state", dbg_state, 0);
        chk("rst/idle_in_ready", in_ready, 1);
        chk("rst/idle_cfg_ready", cfg_ready, 1);
    endtask

    task automatic cfg_write(input logic [IDX_W-1:0] idx, input logic [N_VARS-1:0] care,
                             input logic [N_VARS-1:0] val, input logic en);
        @(negedge clk);
        chk("cfg/cfg_ready", cfg_ready, 1);
        cfg_we = 1'b1; cfg_idx = idx; cfg_care = care; cfg_val = val; cfg_en = en;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    // Sends one vector, measures latency from the acceptance edge, optionally stalls the
    // result for 'hold' cycles while poking a table write that must be ignored.
    task automatic run_vec(input logic [N_VARS-1:0] x, input bit with_wr, input logic exp_f,
                           input logic [IDX_W-1:0] exp_idx, input int exp_lat, input int hold,
                           input string tag);
        int lat;
        @(negedge clk);
        chk({tag, "/in_ready"}, in_ready, 1);
        in_valid = 1'b1; in_x = x;
        if (with_wr) begin
            cfg_we = 1'b1; cfg_idx = '0; cfg_care = '0; cfg_val = '0; cfg_en = 1'b1;
        end
        @(negedge clk);
        in_valid = 1'b0; cfg_we = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "/latency"}, lat, exp_lat);
        chk({tag, "/out_f"}, out_f, exp_f);
`ifdef SOP_HIT_IDX_EN
        chk({tag, "/hit_idx"}, out_hit_idx, exp_idx);
`else
        if (exp_idx != exp_idx) chk({tag, "/unused"}, 0, 1);
`endif
        for (int i = 0; i < hold; i++) begin
            cfg_we = 1'b1; cfg_idx = 3'd2; cfg_care = '0; cfg_val = 5'h1f; cfg_en = 1'b0;
            @(negedge clk);
            chk({tag, "/hold_valid"}, out_valid, 1);
            chk({tag, "/hold_f"}, out_f, exp_f);
            chk({tag, "/hold_in_ready"}, in_ready, 0);
            chk({tag, "/hold_cfg_ready"}, cfg_ready, 0);
`ifdef SOP_HIT_IDX_EN
            chk({tag, "/hold_idx"}, out_hit_idx, exp_idx);
`endif
        end
        cfg_we = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "/post_valid"}, out_valid, 0);
        chk({tag, "/post_in_ready"}, in_ready, 1);
    endtask

    initial begin
        do_reset();

        // Tautology at entry 0
        cfg_write(3'd0, 5'b00000, 5'b00000, 1'b1);
        run_vec(5'b10101, 1'b0, 1'b1, 3'd0, 1, 0, "taut");

        // Fresh table: full miss scan
        do_reset();
        run_vec(5'b10101, 1'b0, 1'b0, 3'd0, 8, 0, "empty");

        // First-hit priority
        cfg_write(3'd2, 5'b10011, 5'b00011, 1'b1);
        cfg_write(3'd5, 5'b00001, 5'b00001, 1'b1);
        run_vec(5'b00011, 1'b0, 1'b1, 3'd2, 3, 0, "prio2");
        run_vec(5'b00001, 1'b0, 1'b1, 3'd5, 6, 0, "prio5");

        // Only entry 2 left: miss
        cfg_write(3'd5, 5'b00001, 5'b00001, 1'b0);
        run_vec(5'b10000, 1'b0, 1'b0, 3'd0, 8, 0, "miss");

        // Backpressure with ignored write, then confirm entry 2 unchanged
        run_vec(5'b00011, 1'b0, 1'b1, 3'd2, 3, 5, "bp");
        run_vec(5'b00011, 1'b0, 1'b1, 3'd2, 3, 0, "reread");

        // Same-cycle write and accept
        run_vec(5'b00000, 1'b1, 1'b1, 3'd0, 1, 0, "wr_acc");

        // Reset mid-scan
        cfg_write(3'd0, 5'b00000, 5'b00000, 1'b0);
        @(negedge clk);
        in_valid = 1'b1; in_x = 5'b10000;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        chk("midrst/scan_state", dbg_state, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst/out_valid", out_valid, 0);
        chk("midrst/in_ready", in_ready, 0);
        chk("midrst/cfg_ready", cfg_ready, 0);
        rst = 1'b0;
        run_vec(5'b00011, 1'b0, 1'b0, 3'd0, 8, 0, "cleared");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sop_cube_evaluator.md
# sop_cube_evaluator

Programmable, sequential sum-of-products evaluator: the runtime-loadable successor to our fixed, generated minimised-logic modules. A table of up to MAX_CUBES implicants (care mask + polarity per cube) is loaded through a config port. Each input vector is then scanned against the table one cube per cycle with early exit on the first hit. It sits between a QM-cover loader and any consumer that needs a function swappable without resynthesis; input and output use valid/ready handshakes.

## Interface
- N_VARS, 5, number of input variables; bit i of any vector is variable x_i
- MAX_CUBES, 8, table depth (≥1)
- IDX_W, max(1, clog2(MAX_CUBES)), derived; not to be overridden
- clk  in  1  clock, rising edge
- rst  in  1  reset; one clock; reset is synchronous and active-high
- cfg_we  in  1  table write strobe
- cfg_idx  in  IDX_W  entry to write
- cfg_care  in  N_VARS  1 = literal present in cube
- cfg_val  in  N_VARS  required value where care=1
- cfg_en  in  1  entry enable
- cfg_ready  out  1  table writable (IDLE only)
- in_valid  in  1  input vector valid
- in_ready  out  1  evaluator can accept a vector
- in_x  in  N_VARS  input vector
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_f  out  1  function value
- out_hit_idx  out  IDX_W  first matching entry (only with SOP_HIT_IDX_EN)

## Operation
- Match rule: entry k matches x iff en[k] and ((x ^ val[k]) & care[k]) == 0. A cube with care=0 and en=1 is a tautology.
- FSM states: IDLE, SCAN, DONE.
- IDLE: in_ready=1, cfg_ready=1. A cfg_we writes {care, val, en} at cfg_idx on the edge. cfg_idx ≥ MAX_CUBES is ignored. On in_valid&in_ready, latch in_x, set scan index to 0, and go to SCAN.
- SCAN: test the entry at the scan index each cycle.
  - Hit: out_f=1, record index, go to DONE.
  - Miss at index MAX_CUBES-1: out_f=0, hit index 0, go to DONE.
  - Otherwise: increment the index.
- DONE: out_valid=1. On out_ready, go to IDLE. out_f and out_hit_idx hold stable while out_valid && !out_ready.
- in_ready=0 and cfg_ready=0 in SCAN and DONE. cfg_we outside IDLE is ignored with no side effect.
- Simultaneous cfg_we and input acceptance in IDLE: the write lands on that edge and the scan uses the updated table.
- Empty or all-disabled table: every vector yields out_f=0 after a full scan.
- Reset values:
  - state=IDLE
  - all en=0; care/val=0
  - out_valid=0, out_f=0, out_hit_idx=0
  - in_ready=0 and cfg_ready=0 while rst is high
- Reset mid-operation aborts any scan or pending result; the result is discarded and the table is cleared.

## Timing
- Acceptance edge E0. A hit at entry k raises out_valid after edge E(k+1), i.e. k+1 cycles after acceptance.
- A miss raises out_valid after E(MAX_CUBES).
- Output handshake edge returns to IDLE; in_ready=1 in the following cycle. Minimum back-to-back period = hit latency + 2 cycles.
- No combinational path from in_valid or out_ready to any output except through registered state. in_ready/cfg_ready are decoded from state and rst only.

## Configuration
- SOP_HIT_IDX_EN defined: port out_hit_idx is present and reports the first matching enabled entry, or 0 on a miss.
- SOP_HIT_IDX_EN undefined: port and index register are removed; all other behaviour and timing are identical.

## Test plan
- Tautology: after reset, write entry 0 care=0 en=1; send x=5'b10101 -> out_valid 1 cycle after acceptance, out_f=1, out_hit_idx=0.
- First-hit priority: entry 2 care=5'b10011 val=5'b00011, entry 5 care=5'b00001 val=5'b00001, both enabled; x=5'b00011 -> out_f=1, hit_idx=2, latency 3. x=5'b00001 -> hit_idx=5, latency 6.
- Miss / empty table: only entry 2 from the previous test loaded; x=5'b10000 -> out_f=0, hit_idx=0, latency 8. Freshly reset table, any x -> out_f=0, latency 8.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> out_valid/out_f/out_hit_idx stable, in_ready=0, cfg_we with new data ignored (reread confirms old entry).
- Same-cycle write+accept: in IDLE, write entry 0 care=0 en=1 while accepting x=0 -> out_f=1, latency 1.
- Reset mid-scan: assert rst in SCAN cycle 3 -> next cycle out_valid=0, in_ready=0. After release, any x -> out_f=0 after 8 cycles (table cleared).
